btn_points_capture: RTL

- Input-side front end of the scoreboard datapath; produces the 2-bit point value consumed by the adder/subtractor.
- Synchronises and debounces the three raw point buttons.
- Converts each qualified press into one point event carrying the point value, team select and add/subtract flag.
- Delivers each event over a valid/ready handshake, so every press is applied exactly once to the score registers.

---
 rtl/btn_points_pkg.sv | 35 +++
 rtl/debounce_bit.sv | 55 +++++
 rtl/btn_points_capture.sv | 121 ++++++++++++
 3 files changed

// File: rtl/btn_points_pkg.sv
// Shared types and constants for the button point-capture front end.
// Optional auto-repeat is enabled by defining BTN_AUTO_REPEAT_EN.
package btn_points_pkg;

    localparam int unsigned DEB_CNT_W = 4;

    localparam logic [1:0] PTS_NONE = 2'd0;
    localparam logic [1:0] PTS_1    = 2'd1;
    localparam logic [1:0] PTS_2    = 2'd2;
    localparam logic [1:0] PTS_3    = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_REL = 2'd2
    } captureState_t;

    function automatic logic [1:0] countPressed(input logic [2:0] bits);
        return 2'(bits[0]) + 2'(bits[1]) + 2'(bits[2]);
    endfunction

    // Point value of a one-hot button vector; PTS_NONE otherwise.
    function automatic logic [1:0] ptsOf(input logic [2:0] bits);
        logic [1:0] pts;
        pts = PTS_NONE;
        case (bits)
            3'b001:  pts = PTS_1;
            3'b010:  pts = PTS_2;
            3'b100:  pts = PTS_3;
            default: pts = PTS_NONE;
        endcase
        return pts;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One button: 2-flop synchroniser, polarity normalisation, ce-paced debounce
// counter and a one-clock press edge aligned with the debounced rise.
module debounce_bit
    import btn_points_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = 4,
    parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic ce,
    input  logic raw,
    output logic debounced,
    output logic pressEdge
);

    localparam logic                 RELEASED_LEVEL = BTN_ACTIVE_LOW;
    localparam logic [DEB_CNT_W-1:0] LAST_CNT       = DEB_CNT_W'(DEBOUNCE_TICKS - 1);

    logic [1:0]           syncReg;
    logic [DEB_CNT_W-1:0] cnt;
    logic                 pressed;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) syncReg <= {RELEASED_LEVEL, RELEASED_LEVEL};
        else       syncReg <= {syncReg[0], raw};
    end

    assign pressed = syncReg[1] ^ RELEASED_LEVEL;

    // Level must disagree for DEBOUNCE_TICKS consecutive ce ticks to flip.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            debounced <= 1'b0;
            pressEdge <= 1'b0;
        end else begin
            pressEdge <= 1'b0;
            if (ce) begin
                if (pressed != debounced) begin
                    if (cnt == LAST_CNT) begin
                        debounced <= pressed;
                        pressEdge <= pressed;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + DEB_CNT_W'(1);
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/btn_points_capture.sv
// Debounces the three point buttons and delivers one point event per press
// over valid/ready. Define BTN_AUTO_REPEAT_EN for hold-to-repeat events.
module btn_points_capture
    import btn_points_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = 4,
    parameter bit          BTN_ACTIVE_LOW = 1'b1
`ifdef BTN_AUTO_REPEAT_EN
    ,
    parameter int unsigned REPEAT_TICKS   = 50
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] botoesEntrada,
    input  logic       ce,
    input  logic       chaveTime,
    input  logic       chaveNegativaPositiva,
    input  logic       evento_ready,
    output logic       evento_valid,
    output logic [1:0] pontos,
    output logic       time_sel,
    output logic       subtrair,
    output logic       erro,
    output logic       busy
);

    logic [2:0]    debounced;
    logic [2:0]    pressEdge;
    captureState_t state;

`ifdef BTN_AUTO_REPEAT_EN
    localparam int unsigned          REP_CNT_W = $clog2(REPEAT_TICKS + 1);
    localparam logic [REP_CNT_W-1:0] REP_LAST  = REP_CNT_W'(REPEAT_TICKS - 1);
    logic [REP_CNT_W-1:0] repCnt;
`endif

    for (genvar i = 0; i < 3; i++) begin : gDebounce
        debounce_bit #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
            .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)
        ) uDebounce (
            .clock    (clock),
            .reset    (reset),
            .ce       (ce),
            .raw      (botoesEntrada[i]),
            .debounced(debounced[i]),
            .pressEdge(pressEdge[i])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            evento_valid <= 1'b0;
            pontos       <= PTS_NONE;
            time_sel     <= 1'b0;
            subtrair     <= 1'b0;
            erro         <= 1'b0;
            busy         <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
            repCnt       <= '0;
`endif
        end else begin
            erro <= 1'b0;
            case (state)
                IDLE: begin
                    if (countPressed(pressEdge) == 2'd1) begin
                        pontos       <= ptsOf(pressEdge);
                        time_sel     <= chaveTime;
                        subtrair     <= chaveNegativaPositiva;
                        evento_valid <= 1'b1;
                        busy         <= 1'b1;
                        state        <= SEND;
                    end else if (countPressed(pressEdge) > 2'd1) begin
                        erro  <= 1'b1;
                        busy  <= 1'b1;
                        state <= WAIT_REL;
                    end
                end
                SEND: begin
                    if (evento_ready) begin
                        evento_valid <= 1'b0;
                        pontos       <= PTS_NONE;
                        state        <= WAIT_REL;
`ifdef BTN_AUTO_REPEAT_EN
                        repCnt       <= '0;
`endif
                    end
                end
                WAIT_REL: begin
                    if (debounced == 3'b000) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
`ifdef BTN_AUTO_REPEAT_EN
                    // A single held button re-arms an event every REPEAT_TICKS ticks.
                    else if (countPressed(debounced) == 2'd1) begin
                        if (ce) begin
                            if (repCnt == REP_LAST) begin
                                repCnt       <= '0;
                                pontos       <= ptsOf(debounced);
                                time_sel     <= chaveTime;
                                subtrair     <= chaveNegativaPositiva;
                                evento_valid <= 1'b1;
                                state        <= SEND;
                            end else begin
                                repCnt <= repCnt + REP_CNT_W'(1);
                            end
                        end
                    end else begin
                        repCnt <= '0;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
